locked_udm_mult_seq: RTL and testbench

Sequential, parametrised successor to the 8x8 key-locked underdesigned multiplier. It computes an unsigned WIDTH x WIDTH product one 2-bit multiplier digit per cycle. Each 2x2 sub-product runs in exact or underdesigned mode, where 3x3 yields 7, selectable per transaction. A key-mismatch mask corrupts partial products deterministically whenever the loaded key differs from the secret. It sits behind valid/ready handshakes in the obfuscation evaluation datapath.

---
 rtl/locked_udm_mult_seq_pkg.sv | 33 +++
 rtl/locked_udm_mult_seq_if.sv | 30 +++
 rtl/locked_udm_mult_seq_row.sv | 29 ++
 rtl/locked_udm_mult_seq.sv | 122 ++++++++++++
 tb/tb_locked_udm_mult_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/locked_udm_mult_seq_pkg.sv
// Shared types and helpers for the key-locked sequential underdesigned multiplier.
package udm_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // 2x2 unsigned product; the underdesigned variant returns 7 for 3x3
  // so the result always fits in three bits.
  function automatic logic [3:0] udm2x2(input logic [1:0] a,
                                        input logic [1:0] b,
                                        input logic       approx);
    if (approx && (a == 2'd3) && (b == 2'd3)) begin
      return 4'd7;
    end
    return {2'b00, a} * {2'b00, b};
  endfunction

  // Partial-product bit that key index k corrupts when it mismatches.
  function automatic int unsigned mask_pp_bit(input int unsigned k,
                                              input int unsigned half);
    return k / half;
  endfunction

  // Multiplier step during which key index k is applied.
  function automatic int unsigned mask_step(input int unsigned k,
                                            input int unsigned half);
    return k % half;
  endfunction

endpackage

// File: rtl/locked_udm_mult_seq_if.sv
// Operand/result handshake bundle and key-load port for locked_udm_mult_seq.
interface locked_udm_mult_seq_if #(
  parameter int WIDTH = 8,
  parameter int KEY_W = 32
);

  logic               key_load_i;
  logic [KEY_W-1:0]   key_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   op1_i;
  logic [WIDTH-1:0]   op2_i;
  logic               approx_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [2*WIDTH-1:0] product_o;

  // Multiplier side.
  modport slave (
    input  key_load_i, key_i, in_valid_i, op1_i, op2_i, approx_i, out_ready_i,
    output in_ready_o, out_valid_o, product_o
  );

  // Producer/consumer side.
  modport master (
    output key_load_i, key_i, in_valid_i, op1_i, op2_i, approx_i, out_ready_i,
    input  in_ready_o, out_valid_o, product_o
  );

endinterface

// File: rtl/locked_udm_mult_seq_row.sv
// One partial-product row: multiplicand times one 2-bit multiplier digit,
// built from 2x2 blocks, then XORed with the key-mismatch mask slice.
module udm_row
  import udm_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_op1,
  input  logic [1:0]       i_b,
  input  logic             i_approx,
  input  logic [WIDTH+1:0] i_mask,
  output logic [WIDTH+1:0] o_pp
);

  localparam int PP_W = WIDTH + 2;

  // Sum the shifted 2x2 sub-products; the exact sum peaks at 3*(2^WIDTH-1)
  // so WIDTH+2 bits never overflow.
  always_comb begin
    logic [PP_W-1:0] v_sum;
    // NOTE: every combinational output gets a default before any branch or loop, so no latch can be inferred.
    v_sum = '0;
    for (int j = 0; j < WIDTH / 2; j++) begin
      v_sum = v_sum + (PP_W'(udm2x2(i_op1[2*j +: 2], i_b, i_approx)) << (2 * j));
    end
    o_pp = v_sum ^ i_mask;
  end

endmodule

// File: rtl/locked_udm_mult_seq.sv
// Key-locked WIDTH x WIDTH multiplier, one 2-bit multiplier digit per cycle,
// with exact or underdesigned 2x2 blocks selected per transaction.
module locked_udm_mult_seq
  import udm_mult_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               KEY_W      = 32,
  parameter logic [KEY_W-1:0] KEY_SECRET = 32'hA5C3_1E7B
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  locked_udm_mult_seq_if.slave bus
);

  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned PP_W   = WIDTH + 2;
  localparam int unsigned P_W    = 2 * WIDTH;
  localparam int unsigned STEP_W = (HALF > 1) ? $clog2(HALF) : 1;

  state_e             r_state;
  state_e             w_next_state;
  logic [STEP_W-1:0]  r_step;
  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   r_mis;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic               r_approx;
  logic [P_W-1:0]     r_acc;
  logic [P_W-1:0]     r_product;

  logic               w_accept;
  logic               w_last;
  logic [1:0]         w_b;
  logic [PP_W-1:0]    w_mask;
  logic [PP_W-1:0]    w_pp;
  logic [P_W-1:0]     w_acc_next;

  assign w_accept   = bus.in_valid_i && (r_state == ST_IDLE);
  assign w_last     = (r_step == STEP_W'(HALF - 1));
  assign w_b        = r_op2[{r_step, 1'b0} +: 2];
  assign w_acc_next = r_acc + (P_W'(w_pp) << {r_step, 1'b0});

  // Gather the mismatch bits that land on this step into a pp-wide flip mask.
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < KEY_W; k++) begin
      if ((mask_step(k, HALF) == 32'(r_step)) && (mask_pp_bit(k, HALF) < PP_W)) begin
        w_mask[mask_pp_bit(k, HALF)] = r_mis[k];
      end
    end
  end

  udm_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .i_op1    (r_op1),
    .i_b      (w_b),
    .i_approx (r_approx),
    .i_mask   (w_mask),
    .o_pp     (w_pp)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_next_state = ST_CALC;
      ST_CALC: if (w_last)            w_next_state = ST_DONE;
      ST_DONE: if (bus.out_ready_i)   w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // Key register, operand/mismatch snapshot, step counter and accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key     <= '0;
      r_mis     <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_approx  <= 1'b0;
      r_step    <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      // NOTE: non-blocking assignments make the accept snapshot read the key as it was before this edge's load.
      if ((r_state == ST_IDLE) && bus.key_load_i) begin
        r_key <= bus.key_i;
      end
      if (w_accept) begin
        r_op1    <= bus.op1_i;
        r_op2    <= bus.op2_i;
        r_approx <= bus.approx_i;
        r_mis    <= r_key ^ KEY_SECRET;
        r_acc    <= '0;
        r_step   <= '0;
      end
      if (r_state == ST_CALC) begin
        r_acc  <= w_acc_next;
        r_step <= r_step + STEP_W'(1);
        if (w_last) begin
          r_product <= w_acc_next;
        end
      end
    end
  end

  // Ready is held low for the whole time reset is asserted, not just in IDLE.
  assign bus.in_ready_o  = rst_ni && (r_state == ST_IDLE);
  assign bus.out_valid_o = (r_state == ST_DONE);
  assign bus.product_o   = r_product;

endmodule

// File: tb/tb_locked_udm_mult_seq.sv
// Directed bench for locked_udm_mult_seq at WIDTH=8: a vector table plus
// hand-written sequences for backpressure, key-load timing and mid-op reset.
module tb_locked_udm_mult_seq;

  localparam int          WIDTH  = 8;
  localparam int          KEY_W  = 32;
  localparam logic [31:0] SECRET = 32'hA5C3_1E7B;

  logic clk_i;
  logic rst_ni;

  locked_udm_mult_seq_if #(.WIDTH(WIDTH), .KEY_W(KEY_W)) bus ();

  locked_udm_mult_seq #(
    .WIDTH      (WIDTH),
    .KEY_W      (KEY_W),
    .KEY_SECRET (SECRET)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] key;
    logic        approx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];
  int   n_vec;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; loads a key while IDLE.
  task automatic load_key(input logic [31:0] k);
    bus.key_load_i = 1'b1;
    bus.key_i      = k;
    @(negedge clk_i);
    bus.key_load_i = 1'b0;
  endtask

  // Waits (bounded) for out_valid, returns product and latency in cycles
  // after the accept edge, then completes the output handshake.
  task automatic wait_collect(input int start, output logic [15:0] p, output int lat);
    lat = start;
    while (!bus.out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    p = bus.product_o;
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;
  endtask

  // Called at a negedge while IDLE; one complete transaction.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ap,
                        output logic [15:0] p, output int lat);
    bus.op1_i      = a;
    bus.op2_i      = b;
    bus.approx_i   = ap;
    bus.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    wait_collect(0, p, lat);
  endtask

  initial begin
    logic [15:0] p;
    int          lat;

    n_vec  = 0;
    n_fail = 0;

    vecs[0]  = '{SECRET,              1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{SECRET,              1'b1, 8'hFF, 8'hFF, 16'hC58F};
    vecs[2]  = '{SECRET,              1'b1, 8'h12, 8'h34, 16'h03A8};
    vecs[3]  = '{SECRET,              1'b1, 8'hA5, 8'h5A, 16'h3A02};
    vecs[4]  = '{SECRET,              1'b0, 8'h03, 8'h03, 16'h0009};
    vecs[5]  = '{SECRET,              1'b1, 8'h03, 8'h03, 16'h0007};
    vecs[6]  = '{SECRET ^ 32'h1,      1'b0, 8'h00, 8'h00, 16'h0001};
    vecs[7]  = '{SECRET ^ 32'h1,      1'b1, 8'h00, 8'h00, 16'h0001};
    vecs[8]  = '{SECRET ^ 32'h2,      1'b0, 8'h00, 8'h00, 16'h0004};
    vecs[9]  = '{SECRET ^ 32'h8000_0000, 1'b0, 8'h00, 8'h00, 16'h2000};
    vecs[10] = '{SECRET ^ 32'h10,     1'b0, 8'h0F, 8'h0F, 16'h00E3};

    bus.key_load_i  = 1'b0;
    bus.key_i       = '0;
    bus.in_valid_i  = 1'b0;
    bus.op1_i       = '0;
    bus.op2_i       = '0;
    bus.approx_i    = 1'b0;
    bus.out_ready_i = 1'b0;
    rst_ni          = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready",  32'(bus.in_ready_o),  32'h0);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'h0);
    check("rst_product",   32'(bus.product_o),   32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_in_ready", 32'(bus.in_ready_o), 32'h1);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      load_key(vecs[i].key);
      run_op(vecs[i].a, vecs[i].b, vecs[i].approx, p, lat);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // Backpressure: hold out_ready low with in_valid pulses in DONE.
    load_key(SECRET);
    bus.op1_i = 8'h03; bus.op2_i = 8'h05; bus.approx_i = 1'b0; bus.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      bus.op1_i = 8'hFF; bus.op2_i = 8'hFF; bus.in_valid_i = 1'b1;
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      check($sformatf("hold%0d_product", i),  32'(bus.product_o),   32'h000F);
      check($sformatf("hold%0d_in_ready", i), 32'(bus.in_ready_o),  32'h0);
      check($sformatf("hold%0d_valid", i),    32'(bus.out_valid_o), 32'h1);
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;
    check("after_hs_valid",    32'(bus.out_valid_o), 32'h0);
    check("after_hs_in_ready", 32'(bus.in_ready_o),  32'h1);
    check("after_hs_product",  32'(bus.product_o),   32'h000F);
    repeat (3) @(negedge clk_i);
    check("no_ghost_op_valid", 32'(bus.out_valid_o), 32'h0);

    // key_load during CALC is ignored for this and the next op.
    bus.op1_i = 8'h00; bus.op2_i = 8'h00; bus.approx_i = 1'b0; bus.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    bus.key_load_i = 1'b1;
    bus.key_i      = SECRET ^ 32'h1;
    @(negedge clk_i);
    bus.key_load_i = 1'b0;
    wait_collect(1, p, lat);
    check("calc_keyload_product", 32'(p), 32'h0);
    run_op(8'h00, 8'h00, 1'b0, p, lat);
    check("calc_keyload_next", 32'(p), 32'h0);

    // key_load with accept: this op uses the old key, the next one the new key.
    bus.op1_i = 8'h00; bus.op2_i = 8'h00; bus.approx_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.key_load_i = 1'b1;
    bus.key_i      = SECRET ^ 32'h1;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    bus.key_load_i = 1'b0;
    wait_collect(0, p, lat);
    check("accept_keyload_old", 32'(p), 32'h0);
    run_op(8'h00, 8'h00, 1'b0, p, lat);
    check("accept_keyload_new", 32'(p), 32'h1);

    // Reset at step 2 discards the in-flight op.
    load_key(SECRET);
    bus.op1_i = 8'hFF; bus.op2_i = 8'hFF; bus.approx_i = 1'b0; bus.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_valid",    32'(bus.out_valid_o), 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready_o),  32'h0);
    check("midrst_product",  32'(bus.product_o),   32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rel_in_ready", 32'(bus.in_ready_o),  32'h1);
    check("rel_valid",    32'(bus.out_valid_o), 32'h0);
    load_key(SECRET);
    run_op(8'h03, 8'h05, 1'b0, p, lat);
    check("fresh_product", 32'(p),   32'h000F);
    check("fresh_latency", 32'(lat), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
